// File: rtl/prog_run_monitor.sv
// prog_run_monitor
// Supervises one program run on an attached core. It holds the core in reset
// for RST_CYC cycles with a latched start PC, then watches the core PC and
// writeback value. Each check channel captures the writeback seen the first
// time the core PC equals that channel's sample PC. The run ends when the PC
// reaches end_pc or the watchdog expires. A one-cycle CHECK state then folds
// the per-channel results into the summary outputs, which stay stable in DONE.
//
// Ports
//   CLK          : clock, rising edge
//   resetl       : synchronous active-low reset
//   start        : one-cycle pulse, begins a run (honoured in IDLE and DONE)
//   run_startpc  : start PC handed to the core
//   end_pc       : run completes when currentpc >= end_pc (unsigned)
//   chk_pc       : per-channel sample PC, channel i at [i*PC_W +: PC_W]
//   chk_exp      : per-channel expected value, channel i at [i*DATA_W +: DATA_W]
//   chk_en       : per-channel enable
//   currentpc    : core PC
//   MemtoRegOut  : core writeback value
//   core_resetl  : core reset, active low
//   core_startpc : latched start PC for the core
//   busy         : high in RSTHOLD, RUN and CHECK
//   done         : run finished, results valid
//   pass         : no timeout and every enabled channel hit and matched
//   timeout      : watchdog expired before end_pc was reached
//   fail_mask    : enabled channels that mismatched or were never hit
//   pass_cnt     : number of enabled channels that hit and matched
//   cycle_cnt    : cycles counted in RUN (saturating)
module prog_run_monitor #(
   parameter int                PC_W      = 64,
   parameter int                DATA_W    = 64,
   parameter int                NCHK      = 4,
   parameter int                WDT_W     = 16,
   parameter logic [WDT_W-1:0]  WDT_LIMIT = 16'hFF,
   parameter int                RST_CYC   = 2
) (
   input  logic                   CLK,
   input  logic                   resetl,
   input  logic                   start,
   input  logic [PC_W-1:0]        run_startpc,
   input  logic [PC_W-1:0]        end_pc,
   input  logic [NCHK*PC_W-1:0]   chk_pc,
   input  logic [NCHK*DATA_W-1:0] chk_exp,
   input  logic [NCHK-1:0]        chk_en,
   input  logic [PC_W-1:0]        currentpc,
   input  logic [DATA_W-1:0]      MemtoRegOut,
   output logic                   core_resetl,
   output logic [PC_W-1:0]        core_startpc,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic                   timeout,
   output logic [NCHK-1:0]        fail_mask,
   output logic [7:0]             pass_cnt,
   output logic [WDT_W-1:0]       cycle_cnt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RSTHOLD = 3'd1,
      RUN     = 3'd2,
      CHECK   = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam int               RCW      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYC - 1);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_LIMIT - {{(WDT_W-1){1'b0}}, 1'b1};
   localparam logic [WDT_W-1:0] CNT_MAX  = {WDT_W{1'b1}};

   state_t          state_r;
   state_t          state_nxt_s;
   logic [RCW-1:0]  rst_cnt_r;
   logic [NCHK-1:0] hit_r;        // channel has seen its sample PC this run
   logic [NCHK-1:0] ok_r;         // captured writeback matched the expected value
   logic [NCHK-1:0] match_s;
   logic [NCHK-1:0] cmp_ok_s;
   logic [NCHK-1:0] new_hit_s;
   logic [NCHK-1:0] fail_calc_s;
   logic            end_reached_s;
   logic            wdt_expired_s;

   // Number of set bits in a channel vector.
   function automatic logic [7:0] count_ones(input logic [NCHK-1:0] v);
      logic [7:0] c;
      c = 8'd0;
      for (int i = 0; i < NCHK; i++) begin
         if (v[i]) begin
            c = c + 8'd1;
         end else begin
            c = c;
         end
      end
      return c;
   endfunction

   // Per-channel PC match and value compare; only unhit channels may capture.
   always_comb begin
      match_s  = '0;
      cmp_ok_s = '0;
      for (int i = 0; i < NCHK; i++) begin
         match_s[i]  = chk_en[i] && (currentpc == chk_pc[i*PC_W +: PC_W]);
         cmp_ok_s[i] = (MemtoRegOut == chk_exp[i*DATA_W +: DATA_W]);
      end
      new_hit_s     = match_s & ~hit_r;
      fail_calc_s   = chk_en & (~hit_r | ~ok_r);
      end_reached_s = (currentpc >= end_pc);
      wdt_expired_s = (cycle_cnt == WDT_LAST);
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nxt_s = RSTHOLD;
            else       state_nxt_s = IDLE;
         end
         RSTHOLD: begin
            if (rst_cnt_r == RST_LAST) state_nxt_s = RUN;
            else                       state_nxt_s = RSTHOLD;
         end
         RUN: begin
            if (end_reached_s || wdt_expired_s) state_nxt_s = CHECK;
            else                                state_nxt_s = RUN;
         end
         CHECK: begin
            state_nxt_s = DONE;
         end
         DONE: begin
            if (start) state_nxt_s = RSTHOLD;
            else       state_nxt_s = DONE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register, run bookkeeping and registered outputs.
   always_ff @(posedge CLK) begin
      if (!resetl) begin
         state_r      <= IDLE;
         rst_cnt_r    <= '0;
         hit_r        <= '0;
         ok_r         <= '0;
         core_resetl  <= 1'b0;
         core_startpc <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         timeout      <= 1'b0;
         fail_mask    <= '0;
         pass_cnt     <= 8'd0;
         cycle_cnt    <= '0;
      end else begin
         state_r <= state_nxt_s;
         busy    <= (state_nxt_s == RSTHOLD) || (state_nxt_s == RUN) ||
                    (state_nxt_s == CHECK);
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  core_startpc <= run_startpc;
                  core_resetl  <= 1'b0;
                  rst_cnt_r    <= '0;
               end else begin
                  core_resetl  <= 1'b1;
               end
            end
            RSTHOLD: begin
               if (rst_cnt_r == RST_LAST) begin
                  // Release the core and start a fresh result set.
                  core_resetl <= 1'b1;
                  cycle_cnt   <= '0;
                  fail_mask   <= '0;
                  pass_cnt    <= 8'd0;
                  hit_r       <= '0;
                  ok_r        <= '0;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  timeout     <= 1'b0;
               end else begin
                  rst_cnt_r   <= rst_cnt_r + {{(RCW-1){1'b0}}, 1'b1};
               end
            end
            RUN: begin
               hit_r <= hit_r | new_hit_s;
               ok_r  <= (ok_r & ~new_hit_s) | (cmp_ok_s & new_hit_s);
               // The counter only advances while the run continues, so on a
               // watchdog exit it reads WDT_LIMIT-1. end_pc beats the watchdog.
               if (end_reached_s) begin
                  timeout <= 1'b0;
               end else if (wdt_expired_s) begin
                  timeout <= 1'b1;
               end else if (cycle_cnt != CNT_MAX) begin
                  cycle_cnt <= cycle_cnt + {{(WDT_W-1){1'b0}}, 1'b1};
               end else begin
                  cycle_cnt <= cycle_cnt;
               end
            end
            CHECK: begin
               fail_mask <= fail_calc_s;
               pass_cnt  <= count_ones(chk_en & hit_r & ok_r);
               pass      <= ~timeout & ~(|(fail_calc_s & chk_en));
               done      <= 1'b1;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
